// File: rtl/i2c_multibus_monitor.sv
// i2c_multibus_monitor: passive multi-bus I2C event decoder with a Wishbone-drained event FIFO
module i2c_multibus_monitor #(
  parameter int NUM_I2C_BUSSES = 1,
  parameter int FIFO_DEPTH     = 16,
  parameter int SYNC_STAGES    = 2
) (
  input  logic                      clk_i,
  input  logic                      rst_i,
  input  logic                      cyc_i,
  input  logic                      stb_i,
  input  logic                      we_i,
  input  logic [1:0]                adr_i,
  input  logic [7:0]                dat_i,
  output logic [7:0]                dat_o,
  output logic                      ack_o,
  output logic                      irq,
  input  logic [NUM_I2C_BUSSES-1:0] scl_i,
  input  logic [NUM_I2C_BUSSES-1:0] sda_i
);
  localparam int N  = NUM_I2C_BUSSES;
  localparam int AW = $clog2(FIFO_DEPTH);
  typedef enum logic [1:0] {IDLE, ADDR, DATA} st_t;
  logic [N-1:0] scl_sync_q [SYNC_STAGES];
  logic [N-1:0] sda_sync_q [SYNC_STAGES];
  logic [N-1:0] scl_s, sda_s, scl_p_q, sda_p_q, sta, sto, rise;
  st_t          st_q [N], st_d [N];
  logic [3:0]   cnt_q [N], cnt_d [N];
  logic [7:0]   sh_q [N], sh_d [N];
  logic [N-1:0] ev_v;
  logic [15:0]  ev_dat [N];
  logic [N-1:0] pv_q, pv_d;
  logic [15:0]  pd_q [N], pd_d [N];
  logic [3:0]   rr_q, rr_d;
  logic         gnt_v, slot_ovf;
  int           gnt_i, idx;
  logic [15:0]  gnt_dat, head;
  logic [15:0]  mem [FIFO_DEPTH];
  logic [AW-1:0] wp_q, wp_d, rp_q, rp_d;
  logic [AW:0]  fcnt_q, fcnt_d;
  logic [6:0]   ctrl_q, ctrl_d;
  logic         ovf_q, ovf_d, ack_q, ack_d, irq_q, irq_d;
  logic [7:0]   dat_q, dat_d, rdata;
  logic         req, wr, flush, pop, push, empty, full, fifo_ovf;

  assign scl_s = scl_sync_q[SYNC_STAGES-1];
  assign sda_s = sda_sync_q[SYNC_STAGES-1];
  assign sta   = scl_s & sda_p_q & ~sda_s;
  assign sto   = scl_s & ~sda_p_q & sda_s;
  assign rise  = scl_s & ~scl_p_q;
  assign empty = fcnt_q == '0;
  assign full  = fcnt_q == (AW+1)'(FIFO_DEPTH);
  assign head  = mem[rp_q];
  assign dat_o = dat_q;
  assign ack_o = ack_q;
  assign irq   = irq_q;

  // Metastability synchronizers plus one delayed copy for edge detection; idle-high on reset
  always_ff @(posedge clk_i or posedge rst_i)
    if (rst_i) begin
      for (int i = 0; i < SYNC_STAGES; i++) begin
        scl_sync_q[i] <= '1;
        sda_sync_q[i] <= '1;
      end
      scl_p_q <= '1;
      sda_p_q <= '1;
    end else begin
      scl_sync_q[0] <= scl_i;
      sda_sync_q[0] <= sda_i;
      for (int i = 1; i < SYNC_STAGES; i++) begin
        scl_sync_q[i] <= scl_sync_q[i-1];
        sda_sync_q[i] <= sda_sync_q[i-1];
      end
      scl_p_q <= scl_s;
      sda_p_q <= sda_s;
    end

  // Per-bus protocol decoders; START/STOP take priority over bit sampling and discard partial bytes
  always_comb begin
    st_d  = st_q;
    cnt_d = cnt_q;
    sh_d  = sh_q;
    ev_v  = '0;
    for (int b = 0; b < N; b++) begin
      ev_dat[b] = '0;
      if (!ctrl_q[0]) begin
        st_d[b]  = IDLE;
        cnt_d[b] = '0;
      end else if (sta[b]) begin
        ev_v[b]   = 1'b1;
        ev_dat[b] = {(st_q[b] == IDLE) ? 3'd1 : 3'd2, 4'(b), 9'd0};
        st_d[b]   = ADDR;
        cnt_d[b]  = '0;
      end else if (sto[b]) begin
        ev_v[b]   = 1'b1;
        ev_dat[b] = {3'd3, 4'(b), 9'd0};
        st_d[b]   = IDLE;
        cnt_d[b]  = '0;
      end else if (rise[b] && st_q[b] != IDLE) begin
        if (cnt_q[b] == 4'd8) begin
          ev_v[b]   = 1'b1;
          ev_dat[b] = {(st_q[b] == ADDR) ? 3'd4 : 3'd5, 4'(b), sda_s[b], sh_q[b]};
          st_d[b]   = DATA;
          cnt_d[b]  = '0;
        end else begin
          sh_d[b]  = {sh_q[b][6:0], sda_s[b]};
          cnt_d[b] = cnt_q[b] + 4'd1;
        end
      end
    end
  end

  // Round-robin grant over pending slots; a slot freed by this cycle's grant may refill at once
  always_comb begin
    gnt_v = 1'b0;
    gnt_i = 0;
    idx   = 0;
    for (int i = N - 1; i >= 0; i--) begin
      idx = (int'(rr_q) + i) % N;
      if (pv_q[idx]) begin
        gnt_v = 1'b1;
        gnt_i = idx;
      end
    end
    gnt_dat  = pd_q[gnt_i];
    rr_d     = gnt_v ? ((gnt_i == N - 1) ? 4'd0 : 4'(gnt_i + 1)) : rr_q;
    pv_d     = pv_q;
    pd_d     = pd_q;
    slot_ovf = 1'b0;
    if (gnt_v) pv_d[gnt_i] = 1'b0;
    for (int b = 0; b < N; b++)
      if (ev_v[b]) begin
        if (pv_d[b]) slot_ovf = 1'b1;
        else begin
          pv_d[b] = 1'b1;
          pd_d[b] = ev_dat[b];
        end
      end
  end

  // Register file, FIFO pointer and Wishbone handshake next-state
  always_comb begin
    req      = cyc_i & stb_i & ~ack_q;
    wr       = req & we_i;
    flush    = wr && adr_i == 2'd0 && dat_i[7];
    pop      = req && !we_i && adr_i == 2'd3 && !empty;
    push     = gnt_v & (~full | pop) & ~flush;
    fifo_ovf = gnt_v & full & ~pop & ~flush;
    rdata    = (adr_i == 2'd0) ? {1'b0, ctrl_q} :
               (adr_i == 2'd1) ? {5'd0, ovf_q, full, empty} :
               empty           ? 8'h00 :
               (adr_i == 2'd2) ? head[15:8] : head[7:0];
    ctrl_d   = (wr && adr_i == 2'd0) ? dat_i[6:0] : ctrl_q;
    ovf_d    = slot_ovf | fifo_ovf | (ovf_q & ~(wr && adr_i == 2'd1 && dat_i[2]));
    ack_d    = req;
    dat_d    = (req && !we_i) ? rdata : 8'h00;
    wp_d     = flush ? '0 : wp_q + AW'(push);
    rp_d     = flush ? '0 : rp_q + AW'(pop);
    fcnt_d   = flush ? '0 : fcnt_q + (AW+1)'(push) - (AW+1)'(pop);
    irq_d    = ctrl_q[1] & ~empty;
  end

  // Decoder, slot, arbiter, FIFO control and bus-interface state
  always_ff @(posedge clk_i or posedge rst_i)
    if (rst_i) begin
      for (int b = 0; b < N; b++) begin
        st_q[b]  <= IDLE;
        cnt_q[b] <= '0;
        sh_q[b]  <= '0;
        pd_q[b]  <= '0;
      end
      pv_q   <= '0;
      rr_q   <= '0;
      wp_q   <= '0;
      rp_q   <= '0;
      fcnt_q <= '0;
      ctrl_q <= '0;
      ovf_q  <= 1'b0;
      ack_q  <= 1'b0;
      dat_q  <= '0;
      irq_q  <= 1'b0;
    end else begin
      st_q   <= st_d;
      cnt_q  <= cnt_d;
      sh_q   <= sh_d;
      pd_q   <= pd_d;
      pv_q   <= pv_d;
      rr_q   <= rr_d;
      wp_q   <= wp_d;
      rp_q   <= rp_d;
      fcnt_q <= fcnt_d;
      ctrl_q <= ctrl_d;
      ovf_q  <= ovf_d;
      ack_q  <= ack_d;
      dat_q  <= dat_d;
      irq_q  <= irq_d;
    end

  // Event storage; contents need no reset since occupancy is tracked separately
  always_ff @(posedge clk_i)
    if (push) mem[wp_q] <= gnt_dat;
endmodule

// File: doc/i2c_multibus_monitor.md
Name: i2c_multibus_monitor

Overview:
Synthesizable passive monitor that watches NUM_I2C_BUSSES I2C busses in parallel. It decodes START, repeated START, STOP, address and data bytes, and ACK/NACK on each bus. Decoded events go into a shared FIFO that software drains through a Wishbone slave port. It sits beside the IICMB controller on the same scl/sda nets and Wishbone bus, giving in-system bus tracing without a bench-side BFM.

Parameters:
NUM_I2C_BUSSES, 1, number of monitored busses (1..16)
FIFO_DEPTH, 16, event FIFO entries (power of 2, >=2)
SYNC_STAGES, 2, synchronizer flops on each scl/sda input (>=2)

Ports:
clk_i  in  1  system clock
rst_i  in  1  asynchronous, active-high reset
cyc_i  in  1  Wishbone valid cycle
stb_i  in  1  Wishbone strobe
we_i  in  1  Wishbone write enable
adr_i  in  2  register address
dat_i  in  8  write data
dat_o  out  8  read data, valid while ack_o=1
ack_o  out  1  Wishbone acknowledge
irq  out  1  interrupt: FIFO non-empty and enabled
scl_i  in  NUM_I2C_BUSSES  I2C clock inputs (observe only)
sda_i  in  NUM_I2C_BUSSES  I2C data inputs (observe only)

Behaviour:
- Clock and reset: one clock, clk_i. Reset rst_i is asynchronous and active-high. While rst_i=1: ack_o=0, dat_o=0x00, irq=0, CTRL=0x00, overflow=0, FIFO empty, all decoders IDLE, pending slots empty, synchronizers loaded with 1.
- Register map:
  - 0 CTRL (RW): bit0 EN, bit1 IRQ_EN, bit7 FLUSH (write 1 empties FIFO; reads as 0).
  - 1 STATUS (R; write bit2=1 clears it): bit0 EMPTY, bit1 FULL, bit2 OVERFLOW (sticky).
  - 2 EVT_HI (R, no pop): head entry bits[15:8].
  - 3 EVT_LO (R): head entry bits[7:0]; pops the head if the FIFO is non-empty.
- Event record, 16 bits:
  - [15:13] type: 1 START, 2 RSTART, 3 STOP, 4 ADDR, 5 DATA.
  - [12:9] bus index.
  - [8] ack bit as sampled (0 = ACK).
  - [7:0] byte (for ADDR: {addr[6:0], rw}); 0 for START/RSTART/STOP.
- Wishbone:
  - ack_o rises the cycle after cyc_i&stb_i are seen and lasts one cycle; no back-to-back ack, so the master must drop stb_i.
  - dat_o is registered with ack_o and returns 0x00 on writes.
  - Reading EVT_LO when empty returns 0x00 and does not pop or underflow.
- Per-bus decoder (all busses identical):
  - Edges are detected on the synchronized signals.
  - START = sda falls while scl=1. STOP = sda rises while scl=1.
  - States: IDLE, ADDR, DATA.
  - START in IDLE: emit START, go to ADDR. START in ADDR/DATA: emit RSTART, go to ADDR. STOP in any state: emit STOP, go to IDLE.
  - In ADDR/DATA, sample sda on each scl rise; bits 1-8 shift in MSB-first, bit 9 is the ack.
  - After the 9th rise, emit ADDR (then go to DATA) or DATA (stay in DATA), and reset the bit counter.
  - A START/STOP arriving mid-byte discards the partial byte.
  - EN=0 holds all decoders in IDLE and emits nothing. Clearing EN mid-transfer aborts silently.
- Arbitration:
  - Each bus has a one-entry pending slot.
  - Round-robin grant among full slots, one FIFO push per cycle. The pointer advances past the granted bus.
  - New event while that bus's slot is still full: event dropped, OVERFLOW set.
  - Grant while FIFO full and no pop this cycle: entry dropped, OVERFLOW set.
  - Push and pop in the same cycle are both allowed, including when full (pop frees space first).
  - FLUSH beats a same-cycle push (the pushed entry is discarded).
- irq is registered: IRQ_EN & ~EMPTY, updated one cycle after the FIFO state changes.

Test Plan:
1. Single write, bus 0: START, address 0x22 W ACK, data 0xA5 ACK, STOP.
   -> FIFO holds four entries: 0x2000, 0x8044, 0xA0A5, 0x6000. Read them via EVT_HI/EVT_LO, then EMPTY=1.
2. Combined transfer, bus 0: write 0x22 with data 0x01, RSTART, read 0x22 with data 0x5C NACK, STOP.
   -> Entries: START, ADDR 0x44, DATA 0x01, RSTART (0x4000), ADDR 0x45, DATA 0x15C, STOP.
3. NUM_I2C_BUSSES=2, STARTs on both busses in the same cycle.
   -> Entries 0x2000 then 0x2200 on consecutive cycles; irq rises when IRQ_EN=1.
4. FIFO_DEPTH=4, six events generated with no reads.
   -> FULL=1, OVERFLOW=1, oldest four entries intact. Writing STATUS=0x04 clears OVERFLOW. FLUSH gives EMPTY=1 and irq=0.
5. rst_i pulsed mid-way through a data byte (asynchronous, between clock edges).
   -> All outputs go to reset values immediately. After release with EN=1, the next START is decoded normally and no partial DATA entry appears.
6. EVT_LO read while empty.
   -> dat_o=0x00, EMPTY stays 1, the next pushed event is read back correctly (no underflow corruption).
